// File: rtl/y86_instr_encoder.sv
// rtl/y86_instr_encoder.sv - Y86-64 instruction encoder: decoded fields to little-endian byte stream
//
// Accepts one decoded instruction per in_valid/in_ready handshake and emits
// its bytes one per cycle on out_valid/out_ready, tagged with a running
// byte address (out_addr) and an end-of-instruction marker (out_last).
// Instructions with an unknown icode are dropped with a one-cycle err pulse.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid, in_ready   instruction handshake
//   icode, ifun, rA, rB  instruction fields
//   valC                 64-bit constant
//   pc_load, pc_in       load out_addr (honoured only while in_ready=1)
//   out_valid, out_ready byte handshake
//   out_byte, out_addr   current byte and its address
//   out_last             current byte is the last of the instruction
//   err                  one-cycle pulse after a rejected instruction
//
// Optional macro ENC_IFUN_CHECK_EN: when defined, ifun is validated per icode
// and a bad ifun is rejected like an invalid icode.

module y86_instr_encoder #(
    parameter int                ADDR_W     = 64,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic [63:0]       valC,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_byte,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              err
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t state, state_next;

    logic [3:0]  icode_r, ifun_r, ra_r, rb_r;
    logic [63:0] valc_r;
    logic [3:0]  idx;
    logic [3:0]  len_r;

    logic [3:0]  in_len;
    logic        in_ok;
    logic        accept, reject, fire;
    logic        need_regids, need_valc;
    logic [2:0]  vsel;

    // Length decode of the incoming icode; length 0 marks an invalid instruction.
    always_comb begin
        in_len = 4'd0;
        in_ok  = 1'b1;
        case (icode)
            4'h0, 4'h1, 4'h9:       in_len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: in_len = 4'd2;
            4'h7, 4'h8:             in_len = 4'd9;
            4'h3, 4'h4, 4'h5:       in_len = 4'd10;
            default:                in_ok  = 1'b0;
        endcase
`ifdef ENC_IFUN_CHECK_EN
        case (icode)
            4'h6:       if (ifun > 4'd3) in_ok = 1'b0;
            4'h2, 4'h7: if (ifun > 4'd6) in_ok = 1'b0;
            default:    if (ifun != 4'd0) in_ok = 1'b0;
        endcase
`endif
    end

    // Field layout follows directly from the latched length:
    // 2 and 10 carry the register byte, 9 and 10 carry valC.
    assign need_regids = (len_r == 4'd2) || (len_r == 4'd10);
    assign need_valc   = (len_r == 4'd9) || (len_r == 4'd10);

    // valC byte number for the current index; wraps correctly for index 8/9.
    assign vsel = idx[2:0] - (need_regids ? 3'd2 : 3'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        accept     = 1'b0;
        reject     = 1'b0;
        fire       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_ok) begin
                        accept     = 1'b1;
                        state_next = EMIT;
                    end else begin
                        reject     = 1'b1;
                    end
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                out_last  = (idx == len_r - 4'd1);
                fire      = out_ready;
                if (out_ready && out_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out_byte = 8'h00;
        if (state == EMIT) begin
            if (idx == 4'd0) begin
                out_byte = {icode_r, ifun_r};
            end else if (need_regids && idx == 4'd1) begin
                out_byte = {ra_r, rb_r};
            end else if (need_valc) begin
                out_byte = valc_r[{vsel, 3'b000} +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            icode_r  <= 4'h0;
            ifun_r   <= 4'h0;
            ra_r     <= 4'h0;
            rb_r     <= 4'h0;
            valc_r   <= 64'h0;
            idx      <= 4'd0;
            len_r    <= 4'd0;
            out_addr <= START_ADDR;
            err      <= 1'b0;
        end else begin
            err <= reject;
            if (in_ready && pc_load) begin
                out_addr <= pc_in;
            end
            if (accept) begin
                icode_r <= icode;
                ifun_r  <= ifun;
                ra_r    <= rA;
                rb_r    <= rB;
                valc_r  <= valC;
                idx     <= 4'd0;
                len_r   <= in_len;
            end
            if (fire) begin
                idx      <= idx + 4'd1;
                out_addr <= out_addr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_y86_instr_encoder.sv
// tb/tb_y86_instr_encoder.sv - directed self-checking bench for y86_instr_encoder

module tb_y86_instr_encoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC;
    logic        pc_load;
    logic [63:0] pc_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic [63:0] out_addr;
    logic        out_last;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0]  exp_b[$];
    logic [63:0] nxt;

    y86_instr_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .icode     (icode),
        .ifun      (ifun),
        .rA        (rA),
        .rB        (rB),
        .valC      (valC),
        .pc_load   (pc_load),
        .pc_in     (pc_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_addr  (out_addr),
        .out_last  (out_last),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] a,
                        input logic [3:0] b, input logic [63:0] c,
                        input logic pl, input logic [63:0] pv);
        icode = ic; ifun = fn; rA = a; rB = b; valC = c;
        pc_load = pl; pc_in = pv; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; pc_load = 1'b0;
    endtask

    // Walks exp_b against the output stream starting at address a0.
    // With stall set, out_ready follows 1,0,0 and stall cycles scramble the inputs.
    task automatic expect_stream(input logic [63:0] a0, input bit stall);
        int i   = 0;
        int cyc = 0;
        int n   = exp_b.size();
        bit rdy;
        while (i < n && cyc < 200) begin
            rdy = stall ? ((cyc % 3) == 0) : 1'b1;
            out_ready = rdy;
            if (!rdy) begin
                in_valid = 1'b1; pc_load = 1'b1; pc_in = 64'hDEAD;
                icode = 4'($urandom); ifun = 4'($urandom);
                rA = 4'($urandom); rB = 4'($urandom);
                valC = {$urandom, $urandom};
            end else begin
                in_valid = 1'b0; pc_load = 1'b0;
            end
            #1;
            chk($sformatf("valid[%0d]", i), 64'(out_valid), 64'd1);
            chk($sformatf("byte[%0d]", i), 64'(out_byte), 64'(exp_b[i]));
            chk($sformatf("addr[%0d]", i), out_addr, a0 + 64'(i));
            chk($sformatf("last[%0d]", i), 64'(out_last), 64'(i == n - 1));
            chk($sformatf("in_ready_busy[%0d]", i), 64'(in_ready), 64'd0);
            tick();
            cyc++;
            if (rdy) i++;
        end
        if (i < n) chk("stream_timeout", 64'(i), 64'(n));
        in_valid = 1'b0; pc_load = 1'b0; out_ready = 1'b1;
        chk("in_ready_after", 64'(in_ready), 64'd1);
        chk("valid_after", 64'(out_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; icode = 0; ifun = 0; rA = 0; rB = 0; valC = 0;
        pc_load = 1'b0; pc_in = 0; out_ready = 1'b1;
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_byte", 64'(out_byte), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_out_addr", out_addr, 64'd0);
        rst = 1'b0;
        tick();

        // mrmovq with pc_load in the same cycle
        send(4'h5, 4'h0, 4'h1, 4'h5, 64'hFFFFFFFFFFFFFFF4, 1'b1, 64'h100);
        exp_b = '{8'h50, 8'h15, 8'hF4, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        expect_stream(64'h100, 1'b0);

        // call: valC right after byte0
        send(4'h8, 4'h0, 4'hF, 4'hF, 64'h0000000000001234, 1'b0, 64'h0);
        exp_b = '{8'h80, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        expect_stream(64'h10A, 1'b0);

        // halt then OPq back to back
        send(4'h0, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0, 64'h0);
        exp_b = '{8'h00};
        expect_stream(64'h113, 1'b0);
        send(4'h6, 4'h1, 4'h2, 4'h3, 64'h0, 1'b0, 64'h0);
        exp_b = '{8'h61, 8'h23};
        expect_stream(64'h114, 1'b0);

        // irmovq with stalls
        send(4'h3, 4'h0, 4'hF, 4'h2, 64'h0123456789ABCDEF, 1'b0, 64'h0);
        exp_b = '{8'h30, 8'hF2, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        expect_stream(64'h116, 1'b1);

        // invalid icode
        chk("pre_err", 64'(err), 64'd0);
        send(4'hD, 4'h0, 4'h1, 4'h2, 64'h55, 1'b0, 64'h0);
        chk("inv_err", 64'(err), 64'd1);
        chk("inv_valid", 64'(out_valid), 64'd0);
        chk("inv_in_ready", 64'(in_ready), 64'd1);
        chk("inv_addr", out_addr, 64'h120);
        tick();
        chk("inv_err_clear", 64'(err), 64'd0);
        chk("inv_valid2", 64'(out_valid), 64'd0);

        // OPq with out-of-range ifun
        send(4'h6, 4'h5, 4'h2, 4'h3, 64'h0, 1'b0, 64'h0);
`ifdef ENC_IFUN_CHECK_EN
        chk("ifun_err", 64'(err), 64'd1);
        chk("ifun_valid", 64'(out_valid), 64'd0);
        chk("ifun_addr", out_addr, 64'h120);
        tick();
        chk("ifun_err_clear", 64'(err), 64'd0);
        nxt = 64'h120;
`else
        chk("ifun_err", 64'(err), 64'd0);
        exp_b = '{8'h65, 8'h23};
        expect_stream(64'h120, 1'b0);
        nxt = 64'h122;
`endif
        chk("addr_next", out_addr, nxt);

        // address wrap at all-ones
        send(4'hA, 4'h0, 4'h3, 4'hF, 64'h0, 1'b1, 64'hFFFFFFFFFFFFFFFF);
        exp_b = '{8'hA0, 8'h3F};
        expect_stream(64'hFFFFFFFFFFFFFFFF, 1'b0);
        chk("wrap_addr", out_addr, 64'd1);

        // reset after the third byte of irmovq
        send(4'h3, 4'h0, 4'hF, 4'h7, 64'h1122334455667788, 1'b0, 64'h0);
        chk("mid_b0", 64'(out_byte), 64'h30);
        tick();
        chk("mid_b1", 64'(out_byte), 64'hF7);
        tick();
        chk("mid_b2", 64'(out_byte), 64'h88);
        tick();
        chk("mid_b3_pre", 64'(out_byte), 64'h77);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_addr", out_addr, 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        #2;
        rst = 1'b0;
        tick();
        send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0, 64'h0);
        exp_b = '{8'h10};
        expect_stream(64'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/y86_instr_encoder.md
Name: y86_instr_encoder

Overview:
- Encoder counterpart of the fetch-stage split/align/need-decode logic.
- Takes one decoded Y86-64 instruction (icode, ifun, rA, rB, valC) per handshake and serialises it into the little-endian byte stream that fetch consumes. The stream runs one byte per cycle over a valid/ready port, with a running byte address.
- Feeds the instruction-memory loader and the self-checking fetch benches.

Parameters:
- ADDR_W, 64, width of the byte address counter out_addr.
- START_ADDR, 0, value of out_addr after reset.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  instruction fields valid.
- in_ready  output  1  encoder can accept an instruction.
- icode  input  4  instruction code.
- ifun  input  4  function code.
- rA  input  4  register A.
- rB  input  4  register B.
- valC  input  64  constant, signed two's complement.
- pc_load  input  1  load byte address; honoured only while in_ready=1.
- pc_in  input  ADDR_W  address loaded by pc_load.
- out_valid  output  1  out_byte valid.
- out_ready  input  1  sink accepts byte.
- out_byte  output  8  current instruction byte.
- out_addr  output  ADDR_W  address of out_byte.
- out_last  output  1  out_byte is the final byte of the instruction.
- err  output  1  one-cycle pulse: rejected instruction.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_byte=0, out_last=0, err=0, out_addr=START_ADDR, state=IDLE.
- Length by icode:
  - 0 halt, 1 nop, 9 ret: 1 byte.
  - 2 cmovXX, 6 OPq, A pushq, B popq: 2 bytes (need_regids).
  - 7 jXX, 8 call: 9 bytes (need_valC).
  - 3 irmovq, 4 rmmovq, 5 mrmovq: 10 bytes (both).
  - C–F: invalid.
- Byte order:
  - byte0 = {icode, ifun}.
  - Then {rA, rB} if need_regids.
  - Then valC bytes [7:0] first up to [63:56] if need_valC.
  - For jXX/call, valC immediately follows byte0.
- States: IDLE, EMIT.
- IDLE:
  - in_ready=1.
  - On pc_load=1: out_addr<=pc_in. If in_valid is also 1 that cycle, the loaded address applies to that instruction's byte0.
  - On in_valid=1 with a valid icode: latch all fields, byte index<=0, len<=decoded length, go to EMIT next cycle (in_ready=0).
  - On in_valid=1 with an invalid icode: instruction dropped, err=1 for exactly the next cycle, stay IDLE, out_addr unchanged.
- EMIT:
  - out_valid=1; out_byte/out_last reflect the current index.
  - out_last=1 when index==len-1.
  - On out_valid&out_ready: index+1, out_addr+1.
  - If out_last, go to IDLE; in_ready returns the next cycle.
  - With out_ready=0: out_byte, out_addr, out_last are held stable, and no input field changes affect them.
- Throughput: one instruction occupies 1 accept cycle + len transfer cycles. No overlap of accept and emit.
- Width rules:
  - out_addr wraps modulo 2^ADDR_W (all-ones +1 -> 0), no flag.
  - Byte index is 4 bits, max 9.
- Reset mid-EMIT:
  - Immediately out_valid=0 and state=IDLE; the partial instruction is discarded.
  - out_addr returns to START_ADDR.
- pc_load during EMIT is ignored.

Optional Feature:
- Macro ENC_IFUN_CHECK_EN.
- Defined, ifun is validated:
  - OPq requires ifun 0–3.
  - jXX and cmovXX require ifun 0–6.
  - All other valid icodes require ifun 0.
  - A violation is treated exactly as an invalid icode: dropped, err pulse, stays IDLE.
- Undefined: ifun is passed through unchecked into byte0 for any valid icode.

Test Plan:
- Reset, then pc_load pc_in=0x100 with mrmovq (icode 5, ifun 0, rA 1, rB 5, valC 0xFFFFFFFFFFFFFFF4), out_ready=1 -> bytes 50 15 F4 FF FF FF FF FF FF FF at addr 0x100–0x109; out_last only on 0x109; in_ready=1 the cycle after.
- call icode 8, valC 0x0000000000001234 -> 9 bytes 80 34 12 00 00 00 00 00 00; no regid byte.
- halt then OPq (icode 6, ifun 1, rA 2, rB 3) back-to-back -> bytes 00 (out_last=1), then 61 23 (out_last on 23) at consecutive addresses.
- irmovq with out_ready toggling 1,0,0,1,... -> byte/addr held during stalls; 10 bytes total, none lost or duplicated.
- icode 0xD -> no out_valid, err=1 for one cycle, out_addr unchanged. With ENC_IFUN_CHECK_EN, OPq ifun 5 -> same response; without it -> bytes 65 xx emitted.
- Assert rst after the 3rd byte of irmovq -> out_valid=0 immediately, out_addr=START_ADDR; the next instruction starts at byte0.
